// File: rtl/sar_logic_pkg.sv
// Shared types and defaults for the SAR ADC controller.
package sar_logic_pkg;

  localparam int SAR_WIDTH = 12;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } sar_state_e;

endpackage

// File: rtl/sar_logic.sv
// SAR controller: drives trial codes to the DAC and resolves one bit per clock, MSB first.
// Build option SAR_AUTO_RESTART_EN: DONE lasts one cycle and a new conversion starts at once.
module sar_logic
  import sar_logic_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d,
  output logic [WIDTH-1:0] bitout,
  output logic             conv_done
);

  localparam logic [WIDTH-1:0] MSB_ONEHOT = {1'b1, {(WIDTH-1){1'b0}}};

  sar_state_e       state_q, state_n;
  logic [WIDTH-1:0] code_q, code_n;
  logic [WIDTH-1:0] ptr_q, ptr_n;
  logic             done_q, done_n;
  logic [WIDTH-1:0] kept;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      code_q  <= '0;
      ptr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      code_q  <= code_n;
      ptr_q   <= ptr_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state_q;
    code_n  = code_q;
    ptr_n   = ptr_q;
    done_n  = done_q;
    // Trial bit under the pointer survives only if the comparator says Vin >= DAC.
    kept    = d ? code_q : (code_q & ~ptr_q);

    case (state_q)
      INIT: begin
        code_n  = MSB_ONEHOT;
        ptr_n   = MSB_ONEHOT;
        done_n  = 1'b0;
        state_n = CONVERT;
      end
      CONVERT: begin
        if (ptr_q[0]) begin
          // LSB just resolved; pointer stays parked rather than wrapping.
          code_n  = kept;
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          code_n = kept | (ptr_q >> 1);
          ptr_n  = ptr_q >> 1;
        end
      end
      DONE: begin
`ifdef SAR_AUTO_RESTART_EN
        code_n  = MSB_ONEHOT;
        ptr_n   = MSB_ONEHOT;
        done_n  = 1'b0;
        state_n = CONVERT;
`else
        state_n = DONE;
`endif
      end
      default: begin
        code_n  = '0;
        ptr_n   = '0;
        done_n  = 1'b0;
        state_n = INIT;
      end
    endcase
  end

  assign bitout    = code_q;
  assign conv_done = done_q;

endmodule

// File: tb/tb_sar_logic.sv
// Randomized self-checking bench for sar_logic against a binary-search reference model.
module tb_sar_logic;
  import sar_logic_pkg::*;

  localparam int W        = SAR_WIDTH;
  localparam int MSB_CODE = 1 << (W - 1);
  localparam int ALL_ONES = (1 << W) - 1;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         d     = 1'b0;
  logic [W-1:0] bitout;
  logic         conv_done;

  int n_checks = 0;
  int n_pass   = 0;

  sar_logic #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .d        (d),
    .bitout   (bitout),
    .conv_done(conv_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset two edges, then release; returns right after edge 1.
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) begin
      d = 1'($urandom_range(0, 1));
      tick();
      check("rst_bitout", int'(bitout), 0);
      check("rst_done", int'(conv_done), 0);
    end
    reset = 1'b0;
    tick();
  endtask

  // Reference: binary search, one decision per step, MSB first.
  // mode 0: d=0, 1: d=1, 2: comparator against vin, 3: random decisions.
  task automatic convert(input int mode, input int vin, output int code);
    int trial;
    bit keep;
    code = 0;
    for (int i = W - 1; i >= 0; i--) begin
      trial = code | (1 << i);
      check("trial_code", int'(bitout), trial);
      check("busy_flag", int'(conv_done), 0);
      case (mode)
        0:       keep = 1'b0;
        1:       keep = 1'b1;
        2:       keep = (vin >= trial);
        default: keep = 1'($urandom_range(0, 1));
      endcase
      d = keep;
      if (keep) code = trial;
      tick();
    end
    check("done_flag", int'(conv_done), 1);
    check("result", int'(bitout), code);
    if (mode == 2) check("result_vs_vin", int'(bitout), vin);
  endtask

  task automatic after_done(input int code);
`ifdef SAR_AUTO_RESTART_EN
    d = 1'($urandom_range(0, 1));
    tick();
    check("restart_done_low", int'(conv_done), 0);
    check("restart_code", int'(bitout), MSB_CODE);
`else
    repeat (22) begin
      d = 1'($urandom_range(0, 1));
      tick();
      check("hold_done", int'(conv_done), 1);
      check("hold_code", int'(bitout), code);
    end
`endif
  endtask

  initial begin
    int code;
    int vin;

    repeat (5) begin
      d = 1'($urandom_range(0, 1));
      tick();
      check("init_bitout", int'(bitout), 0);
      check("init_done", int'(conv_done), 0);
    end
    reset = 1'b0;
    tick();

    convert(1, 0, code);
    check("all_ones", int'(bitout), ALL_ONES);
    after_done(code);

    do_reset();
    convert(0, 0, code);
    check("all_zeros", int'(bitout), 0);
    after_done(code);

    do_reset();
    convert(2, 'hA5C, code);
    after_done(code);

    for (int n = 0; n < 8; n++) begin
      do_reset();
      vin = int'($urandom_range(0, ALL_ONES));
      convert((n % 2 == 0) ? 2 : 3, vin, code);
      after_done(code);
    end

    // Reset lands on edge 6, in the middle of a conversion.
    do_reset();
    repeat (4) begin
      d = 1'($urandom_range(0, 1));
      tick();
    end
    reset = 1'b1;
    tick();
    check("midrst_bitout", int'(bitout), 0);
    check("midrst_done", int'(conv_done), 0);
    reset = 1'b0;
    tick();
    vin = int'($urandom_range(0, ALL_ONES));
    convert(2, vin, code);
    after_done(code);

`ifdef SAR_AUTO_RESTART_EN
    // Back-to-back conversions without reset.
    for (int n = 0; n < 3; n++) begin
      vin = int'($urandom_range(0, ALL_ONES));
      convert(2, vin, code);
      after_done(code);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
